// File: rtl/display_pkg.sv
// Purpose: shared state encoding and default timing constants for the display arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package display_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // One second at 50 MHz per shown value, quarter-second blink half-period.
    localparam int HOLD_CYCLES  = 50_000_000;
    localparam int BLINK_CYCLES = 12_500_000;

endpackage

// File: rtl/display_arbiter_rr.sv
// Purpose: round-robin search over a request vector, starting just after the last owner.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the grant is actually taken.
module rr_arbiter
    import display_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] last,
    output logic [NREQ-1:0]         grant,
    output logic [$clog2(NREQ)-1:0] idx
);

    localparam int IW = $clog2(NREQ);

    // Walk the ring from farthest to nearest so the nearest requester after last wins.
    always_comb begin
        int c;
        c     = 0;
        grant = '0;
        idx   = '0;
        for (int k = NREQ; k >= 1; k--) begin
            c = (int'(last) + k) % NREQ;
            if (req[c[IW-1:0]]) begin
                grant             = '0;
                grant[c[IW-1:0]]  = 1'b1;
                idx               = c[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/display_arbiter.sv
// Purpose: round-robin picks one requester's 6-bit value and holds it on the display for HOLD_CYCLES (optional DISP_BLINK_EN blinks the tail of each hold).
// Latency: accepted value appears on o_data the cycle after its ready strobe, then stays for HOLD_CYCLES cycles.
// Backpressure: o_req_ready strobes only when idle or on the last hold cycle; requesters hold valid until they see it, abort/reset suppress it.
module display_arbiter
    import display_pkg::*;
#(
    parameter int NREQ         = 4,
    parameter int HOLD_CYCLES  = display_pkg::HOLD_CYCLES,
    parameter int BLINK_CYCLES = display_pkg::BLINK_CYCLES
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [NREQ-1:0]         i_req_valid,
    input  logic [NREQ-1:0][5:0]    i_req_data,
    output logic [NREQ-1:0]         o_req_ready,
    input  logic                    i_abort,
    output logic [5:0]              o_data,
    output logic                    o_blank,
    output logic [$clog2(NREQ)-1:0] o_owner,
    output logic                    o_busy
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(HOLD_CYCLES);
    localparam logic [CW-1:0] CNT_INIT = CW'(HOLD_CYCLES - 1);
    localparam logic [IW-1:0] LAST_INIT = IW'(NREQ - 1);

    state_t          state_q;
    state_t          state_d;
    logic [CW-1:0]   cnt_q;
    logic [IW-1:0]   last_q;
    logic [NREQ-1:0] rr_grant;
    logic [IW-1:0]   rr_idx;
    logic            grant_en;

`ifdef DISP_BLINK_EN
    localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [BW-1:0] BLINK_INIT = BW'(BLINK_CYCLES - 1);
    // Blinking covers the final quarter of each hold.
    localparam logic [CW-1:0] BLINK_TH = CW'(HOLD_CYCLES / 4);
    logic [BW-1:0]   blink_q;
`else
    // Only the blinking build consumes BLINK_CYCLES.
    localparam int blink_unused = BLINK_CYCLES;
`endif

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr (
        .req   (i_req_valid),
        .last  (last_q),
        .grant (rr_grant),
        .idx   (rr_idx)
    );

    // A grant may only happen when the display is free: idle, or the final hold cycle.
    assign grant_en    = !i_rst && !i_abort && (|i_req_valid) &&
                         ((state_q == IDLE) || (cnt_q == '0));
    assign o_req_ready = grant_en ? rr_grant : '0;
    assign o_busy      = (state_q == HOLD);

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: abort beats a grant, grant beats expiry.
    always_comb begin
        state_d = state_q;
        if (i_abort) begin
            state_d = IDLE;
        end else if (grant_en) begin
            state_d = HOLD;
        end else if ((state_q == HOLD) && (cnt_q == '0)) begin
            state_d = IDLE;
        end
    end

    // Hold counter, displayed value, owner and blanking.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q   <= '0;
            o_data  <= '0;
            o_owner <= '0;
            o_blank <= 1'b1;
            last_q  <= LAST_INIT;
`ifdef DISP_BLINK_EN
            blink_q <= '0;
`endif
        end else if (i_abort) begin
            cnt_q   <= '0;
            o_blank <= 1'b1;
        end else if (grant_en) begin
            cnt_q   <= CNT_INIT;
            o_data  <= i_req_data[rr_idx];
            o_owner <= rr_idx;
            last_q  <= rr_idx;
            o_blank <= 1'b0;
        end else if (state_q == HOLD) begin
            if (cnt_q != '0) begin
                cnt_q <= cnt_q - CW'(1);
`ifdef DISP_BLINK_EN
                if (cnt_q == BLINK_TH) begin
                    o_blank <= 1'b1;
                    blink_q <= BLINK_INIT;
                end else if (cnt_q < BLINK_TH) begin
                    if (blink_q == '0) begin
                        o_blank <= ~o_blank;
                        blink_q <= BLINK_INIT;
                    end else begin
                        blink_q <= blink_q - BW'(1);
                    end
                end
`endif
            end
`ifdef DISP_BLINK_EN
            else begin
                // Hold expired with nobody waiting: leave the last value visible.
                o_blank <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_display_arbiter.sv
// Purpose: directed and random checks of display_arbiter against a spec-level model.
// Latency: one model step per clock.
// Backpressure: model decides each cycle whether a grant is legal.
module tb_display_arbiter;

    localparam int NREQ  = 4;
    localparam int HOLD  = 4;
    localparam int BLINK = 1;
    localparam int Q     = HOLD / 4;

    logic                 clk;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0][5:0] req_data;
    logic [NREQ-1:0]      req_ready;
    logic                 abort;
    logic [5:0]           data;
    logic                 blank;
    logic [1:0]           owner;
    logic                 busy;

    int checks;
    int errors;

    // Reference model: what the display shows and how long it still has to hold it.
    int m_data, m_owner, m_blank, m_busy, m_rem, m_last;

    display_arbiter #(
        .NREQ         (NREQ),
        .HOLD_CYCLES  (HOLD),
        .BLINK_CYCLES (BLINK)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req_valid (req_valid),
        .i_req_data  (req_data),
        .o_req_ready (req_ready),
        .i_abort     (abort),
        .o_data      (data),
        .o_blank     (blank),
        .o_owner     (owner),
        .o_busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_data  = 0;
        m_owner = 0;
        m_blank = 1;
        m_busy  = 0;
        m_rem   = 0;
        m_last  = NREQ - 1;
    endtask

    // First valid requester found going round the ring after the last owner, or -1.
    function automatic int winner();
        int res;
        int c;
        res = -1;
        for (int k = 1; k <= NREQ; k++) begin
            c = (m_last + k) % NREQ;
            if (res < 0 && req_valid[c[1:0]]) res = c;
        end
        return res;
    endfunction

    // Check one cycle against the model, then step the model and the clock.
    task automatic tick();
        int w;
        logic [NREQ-1:0] er;
        #3;
        w = -1;
        if (!abort && (m_busy == 0 || m_rem == 0)) w = winner();
        er = '0;
        if (w >= 0) er[w[1:0]] = 1'b1;
        chk("ready", {28'd0, req_ready}, {28'd0, er});
        chk("data",  {26'd0, data},  m_data);
        chk("owner", {30'd0, owner}, m_owner);
        chk("blank", {31'd0, blank}, m_blank);
        chk("busy",  {31'd0, busy},  m_busy);
        if (abort) begin
            m_busy  = 0;
            m_blank = 1;
            m_rem   = 0;
        end else if (w >= 0) begin
            m_data  = int'(req_data[w[1:0]]);
            m_owner = w;
            m_last  = w;
            m_blank = 0;
            m_busy  = 1;
            m_rem   = HOLD - 1;
        end else if (m_busy != 0 && m_rem > 0) begin
            m_rem = m_rem - 1;
        end else if (m_busy != 0) begin
            m_busy = 0;
`ifdef DISP_BLINK_EN
            m_blank = 0;
`endif
        end
`ifdef DISP_BLINK_EN
        if (m_busy != 0 && m_rem < Q) m_blank = (((Q - 1 - m_rem) / BLINK) % 2 == 0) ? 1 : 0;
`endif
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_blank;
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        abort     = 1'b0;
        req_valid = 4'b0001;
        req_data  = '0;
        model_reset();

        // Reset values, and no strobe even though req0 is valid.
        #2;
        chk("rst_ready", {28'd0, req_ready}, 0);
        chk("rst_data",  {26'd0, data}, 0);
        chk("rst_owner", {30'd0, owner}, 0);
        chk("rst_blank", {31'd0, blank}, 1);
        chk("rst_busy",  {31'd0, busy}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Single accept of 42 by req0, held 4 cycles, then idle still showing 42.
        req_data[0] = 6'd42;
        req_valid   = 4'b0001;
        #1;
        chk("s1_ready", {28'd0, req_ready}, 4'b0001);
        tick();
        req_valid = '0;
        chk("s1_data",  {26'd0, data}, 42);
        chk("s1_owner", {30'd0, owner}, 0);
        chk("s1_blank", {31'd0, blank}, 0);
        chk("s1_busy",  {31'd0, busy}, 1);
        repeat (4) tick();
        chk("s1_idle_busy", {31'd0, busy}, 0);
        chk("s1_idle_data", {26'd0, data}, 42);

        // req1 and req3 continuously valid: owners alternate 1,3,1 with no idle gap.
        req_data[1] = 6'd7;
        req_data[3] = 6'd59;
        req_valid   = 4'b1010;
        tick();
        chk("s2_owner_a", {30'd0, owner}, 1);
        chk("s2_data_a",  {26'd0, data}, 7);
        repeat (4) tick();
        chk("s2_owner_b", {30'd0, owner}, 3);
        chk("s2_data_b",  {26'd0, data}, 59);
        chk("s2_busy_b",  {31'd0, busy}, 1);
        repeat (4) tick();
        chk("s2_owner_c", {30'd0, owner}, 1);

        // Abort on the second hold cycle blanks; next grant the cycle abort falls.
        tick();
        abort = 1'b1;
        #1;
        chk("s3_abort_ready", {28'd0, req_ready}, 0);
        tick();
        abort = 1'b0;
        chk("s3_blank", {31'd0, blank}, 1);
        chk("s3_busy",  {31'd0, busy}, 0);
        chk("s3_data",  {26'd0, data}, 7);
        #1;
        chk("s3_regrant", {28'd0, req_ready}, 4'b1000);
        tick();
        chk("s3_owner", {30'd0, owner}, 3);
        chk("s3_unblank", {31'd0, blank}, 0);
        req_valid = '0;
        repeat (4) tick();

        // Reset in the middle of a hold acts at once; req0 wins after release.
        req_data[2] = 6'd13;
        req_valid   = 4'b0100;
        tick();
        req_valid   = '0;
        tick();
        req_data[0] = 6'd5;
        req_data[2] = 6'd9;
        req_valid   = 4'b0101;
        rst = 1'b1;
        #1;
        chk("s4_data",  {26'd0, data}, 0);
        chk("s4_owner", {30'd0, owner}, 0);
        chk("s4_blank", {31'd0, blank}, 1);
        chk("s4_busy",  {31'd0, busy}, 0);
        chk("s4_ready", {28'd0, req_ready}, 0);
        model_reset();
        @(posedge clk);
        #1;
        chk("s4_ready_held", {28'd0, req_ready}, 0);
        rst = 1'b0;
        #1;
        chk("s4_first", {28'd0, req_ready}, 4'b0001);
        tick();
        chk("s4_owner0", {30'd0, owner}, 0);
        chk("s4_data5",  {26'd0, data}, 5);
        req_valid = '0;
        repeat (4) tick();

        // Value 63 passes unclamped; blanking over a single isolated hold.
        req_data[3] = 6'd63;
        req_valid   = 4'b1000;
        tick();
        req_valid = '0;
        for (int k = 0; k < HOLD; k++) begin
`ifdef DISP_BLINK_EN
            exp_blank = (k == HOLD - 1) ? 1 : 0;
`else
            exp_blank = 0;
`endif
            chk("s5_data63", {26'd0, data}, 63);
            chk("s5_blank",  {31'd0, blank}, exp_blank);
            tick();
        end

        // Random traffic with occasional aborts.
        repeat (400) begin
            req_valid = 4'($urandom);
            for (int i = 0; i < NREQ; i++) req_data[i] = 6'($urandom_range(0, 63));
            abort = ($urandom_range(0, 15) == 0);
            tick();
        end
        abort     = 1'b0;
        req_valid = '0;
        repeat (6) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
